// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the EXE-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_MUL  = S_MUL,
    ST_DIV  = S_DIV,
    ST_FIX  = S_FIX,
    ST_DONE = S_DONE
  } muldiv_state_t;

  // Only signed DIV can overflow: most-negative dividend over -1.
  function automatic logic is_signed_ovf(input logic [1:0] op,
                                         input logic dvd_is_min,
                                         input logic dvs_is_neg1);
    return (op == OP_DIV) && dvd_is_min && dvs_is_neg1;
  endfunction

endpackage

// File: rtl/muldiv_div_iter_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is high in the cycle whose closing edge performs the final step.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    cnt_d   = cnt_q;
    run_d   = run_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (start) begin
      cnt_d = CNT_W'(XLEN - 1);
      run_d = 1'b1;
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      // Borrow out of the trial subtract means restore the shifted remainder.
      rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// EXE-stage multiply/divide unit with request/response handshakes and flush.
//   state | meaning
//   IDLE  | ready for a request
//   MUL   | product registered, latency counter running
//   DIV   | iterative divider stepping on magnitudes
//   FIX   | apply quotient/remainder signs
//   DONE  | result presented until consumed
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              accept;
  logic              sgn_op;
  logic [2*XLEN-1:0] a_ext, b_ext, prod_now;
  logic [XLEN-1:0]   dvd_mag, dvs_mag;
  logic              div_zero, div_ovf, div_start;
  logic              div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign sgn_op    = ~req_op[0];

  // Extending to 2*XLEN and keeping the low half gives the exact product for both signednesses.
  assign a_ext    = {{XLEN{sgn_op & src1[XLEN-1]}}, src1};
  assign b_ext    = {{XLEN{sgn_op & src2[XLEN-1]}}, src2};
  assign prod_now = a_ext * b_ext;

  assign dvd_mag   = (sgn_op && src1[XLEN-1]) ? -src1 : src1;
  assign dvs_mag   = (sgn_op && src2[XLEN-1]) ? -src2 : src2;
  assign div_zero  = (src2 == '0);
  assign div_ovf   = is_signed_ovf(req_op, src1 == {1'b1, {(XLEN-1){1'b0}}}, src2 == '1);
  assign div_start = accept && req_op[1] && !div_zero && !div_ovf;

  div_iter_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            q_neg_d = sgn_op && (src1[XLEN-1] ^ src2[XLEN-1]);
            r_neg_d = sgn_op && src1[XLEN-1];
            if (!req_op[1]) begin
              prod_d = prod_now;
              cnt_d  = CNT_W'(MUL_LAT - 1);
              if (MUL_LAT == 1) begin
                state_d = S_DONE;
                hi_d    = prod_now[2*XLEN-1:XLEN];
                lo_d    = prod_now[XLEN-1:0];
              end else begin
                state_d = S_MUL;
              end
            end else if (div_zero) begin
              state_d = S_DONE;
              hi_d    = src1;
              lo_d    = '1;
            end else if (div_ovf) begin
              state_d = S_DONE;
              hi_d    = '0;
              lo_d    = src1;
            end else begin
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            hi_d    = prod_q[2*XLEN-1:XLEN];
            lo_d    = prod_q[XLEN-1:0];
          end
        end
        S_DIV: begin
          if (div_done) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          lo_d    = q_neg_q ? -div_quo : div_quo;
          hi_d    = r_neg_q ? -div_rem : div_rem;
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit/2-cycle and a 16-bit/4-cycle instance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, rv, flush, resp_ready, sel;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;
  int          w_cur, lat_cur;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rq32, rs32, bz32, rq16, rs16, bz16;
  logic [31:0] hi32, lo32;
  logic [15:0] hi16, lo16;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2)) u_dut32 (
    .clk(clk), .resetn(resetn), .req_valid(rv && !sel), .req_ready(rq32),
    .req_op(r_op), .src1(r_a), .src2(r_b), .flush(flush),
    .resp_valid(rs32), .resp_ready(resp_ready), .hi(hi32), .lo(lo32), .busy(bz32)
  );

  muldiv_unit #(.XLEN(16), .MUL_LAT(4)) u_dut16 (
    .clk(clk), .resetn(resetn), .req_valid(rv && sel), .req_ready(rq16),
    .req_op(r_op), .src1(r_a[15:0]), .src2(r_b[15:0]), .flush(flush),
    .resp_valid(rs16), .resp_ready(resp_ready), .hi(hi16), .lo(lo16), .busy(bz16)
  );

  logic        rq_m, rs_m, bz_m;
  logic [31:0] hi_m, lo_m;
  assign rq_m = sel ? rq16 : rq32;
  assign rs_m = sel ? rs16 : rs32;
  assign bz_m = sel ? bz16 : bz32;
  assign hi_m = sel ? {16'h0, hi16} : hi32;
  assign lo_m = sel ? {16'h0, lo16} : lo32;

  exp_t        exp_q[$];
  int          errs = 0, checks = 0;
  logic        seen = 1'b0;
  logic        rr_rand = 1'b0, rr_force = 1'b1;
  logic [31:0] held_hi, held_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values at width w.
  function automatic exp_t ref_model(input int w, input int lat, input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] m, ua, ub, pu;
    longint      sa, sb, q, r;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    pu = 64'd0;
    e.acc = 0;
    e.lat = lat;
    if (op == OP_MULT || op == OP_MULTU) begin
      pu   = (op == OP_MULT) ? 64'(sa * sb) : ua * ub;
      e.hi = 32'((pu >> w) & m);
      e.lo = 32'(pu & m);
    end else if (ub == 64'd0) begin
      e.hi = 32'(ua);
      e.lo = 32'(m);
      e.lat = 1;
    end else if (op == OP_DIV && ua == (64'd1 << (w - 1)) && ub == m) begin
      e.hi = 32'd0;
      e.lo = 32'(ua);
      e.lat = 1;
    end else if (op == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
      e.lo = 32'(64'(q) & m);
      e.hi = 32'(64'(r) & m);
      e.lat = w + 2;
    end else begin
      e.lo = 32'(ua / ub);
      e.hi = 32'(ua % ub);
      e.lat = w + 2;
    end
    return e;
  endfunction

  // Monitor: checks each response once, then checks it stays stable until consumed.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rs_m) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_hi", hi_m, e.hi);
          chk("resp_lo", lo_m, e.lo);
          chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
        held_hi = hi_m;
        held_lo = lo_m;
        seen = 1'b1;
      end else begin
        chk("hold_hi", hi_m, held_hi);
        chk("hold_lo", lo_m, held_lo);
      end
    end
    resp_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_force;
    if (rs_m && resp_ready && !flush) seen = 1'b0;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    rv = 1'b1; r_op = op; r_a = a; r_b = b;
    while (!rq_m && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!rq_m) begin
      errs++;
      $display("FAIL issue_timeout actual=not_ready expected=ready t=%0t", $time);
      rv = 1'b0;
      return;
    end
    e = ref_model(w_cur, lat_cur, op, a, b);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 rv = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rs_m) && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errs++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
    end
  endtask

  task automatic rand_ops(input int n);
    logic [1:0]  op;
    logic [31:0] a, b;
    int          k;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      k  = $urandom_range(0, 7);
      if (k == 0) b = 32'd0;
      else if (k == 1) begin
        op = OP_DIV;
        a  = 32'(64'd1 << (w_cur - 1));
        b  = 32'hFFFF_FFFF;
      end else if (k == 2) b = $urandom_range(1, 20);
      issue(op, a, b);
    end
  endtask

  task automatic directed();
    issue(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    issue(OP_DIVU,  32'd100, 32'd7);
    issue(OP_DIVU,  32'h1234_5678, 32'd0);
    issue(OP_DIV,   32'(64'd1 << (w_cur - 1)), 32'hFFFF_FFFF);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; rv = 1'b0; flush = 1'b0; sel = 1'b0; resp_ready = 1'b1;
    r_op = 2'b00; r_a = '0; r_b = '0; w_cur = 32; lat_cur = 2;
    #12;
    chk("rst_resp_valid", 32'(rs_m), 32'd0);
    chk("rst_busy", 32'(bz_m), 32'd0);
    chk("rst_hi", hi_m, 32'd0);
    chk("rst_lo", lo_m, 32'd0);
    chk("rst_req_ready", 32'(rq_m), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    directed();

    // Backpressure in DONE.
    rr_force = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7);
    begin
      int t;
      t = 0;
      while (!rs_m && t < 200) begin
        @(negedge clk);
        #2;
        t++;
      end
      chk("bp_valid_seen", 32'(rs_m), 32'd1);
    end
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("bp_req_ready", 32'(rq_m), 32'd0);
      chk("bp_resp_valid", 32'(rs_m), 32'd1);
    end
    rr_force = 1'b1;
    @(negedge clk);
    #2;
    @(posedge clk);
    #1;
    chk("bp_release_busy", 32'(bz_m), 32'd0);
    chk("bp_release_ready", 32'(rq_m), 32'd1);

    // Flush mid-divide, then a clean divide.
    issue(OP_DIV, $urandom, 32'd13);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(bz_m), 32'd0);
    chk("flush_resp_valid", 32'(rs_m), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    issue(OP_DIVU, 32'd9, 32'd3);
    drain();

    // Flush concurrent with a request in IDLE.
    @(negedge clk);
    flush = 1'b1; rv = 1'b1; r_op = OP_DIVU; r_a = 32'd50; r_b = 32'd5;
    #1;
    chk("flush_idle_ready", 32'(rq_m), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_idle_busy", 32'(bz_m), 32'd0);
    @(negedge clk);
    rv = 1'b0; flush = 1'b0;

    // Reset mid-divide.
    issue(OP_DIV, 32'h7654_3210, 32'd5);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(rs_m), 32'd0);
    chk("midrst_busy", 32'(bz_m), 32'd0);
    chk("midrst_hi", hi_m, 32'd0);
    chk("midrst_lo", lo_m, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    resetn = 1'b1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    rr_rand = 1'b1;
    rand_ops(40);
    drain();

    // Second configuration: 16-bit operands, 4-cycle multiply.
    rr_rand = 1'b0;
    @(negedge clk);
    sel = 1'b1; w_cur = 16; lat_cur = 4;
    directed();
    rr_rand = 1'b1;
    rand_ops(25);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
